// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble encoding, fetch FSM states.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        F_REQ  = 1'b0,
        F_HOLD = 1'b1
    } fState_t;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/valid bus: level request held until the word returns.
interface fetch_stage_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr, input im_rvalid, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_rvalid, output im_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instr, insert a bubble, or hold.
// Registered outputs; hold wins whenever neither load nor bubble is asserted.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fInstr,
    input  logic [31:0] fPc,
    input  logic [31:0] fPc4,
    output logic [31:0] dInstr,
    output logic [31:0] dPc,
    output logic [31:0] dPc4,
    output logic        dValid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dInstr <= NOP;
            dPc    <= 32'd0;
            dPc4   <= 32'd0;
            dValid <= 1'b0;
        end else if (load) begin
            dInstr <= fInstr;
            dPc    <= fPc;
            dPc4   <= fPc4;
            dValid <= 1'b1;
        end else if (bubble) begin
            // PC fields keep their last value; only the instr is squashed.
            dInstr <= NOP;
            dValid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register for a delay-slot MIPS pipeline over a variable-latency imem.
// One request outstanding; a stalled return is parked in a 1-entry buffer until D accepts it.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] NOP_WORD_P = NOP_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 d_jump_taken,
    input  logic [31:0]          d_target,
    fetch_stage_if.master        imBus,
    output logic [31:0]          D_instr,
    output logic [31:0]          D_pc,
    output logic [31:0]          D_pc4,
    output logic                 D_valid
);

    fState_t     state;
    fState_t     stateNext;
    logic [31:0] fPc;
    logic [31:0] fPc4;
    logic [31:0] bufInstr;
    logic [31:0] redirPc;
    logic        redirPend;
    logic [31:0] nextF;
    logic [31:0] fInstr;
    logic [31:0] targetAligned;
    logic        fReady;
    logic        adv;
    logic        takeRedir;
    logic        bubble;

    assign imBus.im_req  = (state == F_REQ);
    assign imBus.im_addr = fPc;

    assign fPc4          = pcPlus4(fPc);
    assign targetAligned = d_target & ~32'h0000_0003;
    assign fReady        = ((state == F_REQ) && imBus.im_rvalid) || (state == F_HOLD);
    assign fInstr        = imBus.im_rvalid ? imBus.im_rdata : bufInstr;
    assign adv           = fReady && !stall;
    assign takeRedir     = D_valid && d_jump_taken && !stall;
    assign bubble        = !stall && !fReady;

    // A pending redirect outranks a fresh one: the delay slot it belongs to is still in F.
    always_comb begin
        nextF = fPc4;
        if (redirPend) begin
            nextF = redirPc;
        end else if (takeRedir) begin
            nextF = targetAligned;
        end
    end

    always_comb begin
        stateNext = state;
        if (adv) begin
            stateNext = F_REQ;
        end else if ((state == F_REQ) && imBus.im_rvalid && stall) begin
            stateNext = F_HOLD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= F_REQ;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fPc       <= RESET_PC_P;
            bufInstr  <= 32'd0;
            redirPend <= 1'b0;
            redirPc   <= 32'd0;
        end else begin
            if (adv) begin
                fPc       <= nextF;
                redirPend <= 1'b0;
            end else if (takeRedir) begin
                // Jump leaves D before its delay slot arrived; remember where to go after it.
                redirPend <= 1'b1;
                redirPc   <= targetAligned;
            end
            if ((state == F_REQ) && imBus.im_rvalid && stall) begin
                bufInstr <= imBus.im_rdata;
            end
        end
    end

    if_id_reg #(
        .NOP (NOP_WORD_P)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (adv),
        .bubble (bubble),
        .fInstr (fInstr),
        .fPc    (fPc),
        .fPc4   (fPc4),
        .dInstr (D_instr),
        .dPc    (D_pc),
        .dPc4   (D_pc4),
        .dValid (D_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected fetch addresses and D-stage words are queued by stimulus, checked by a monitor.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } dExp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        d_jump_taken;
    logic [31:0] d_target;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc4;
    logic        D_valid;

    fetch_stage_if imBus ();

    int          checks;
    int          errors;
    int          lat;
    int          budgetTarget;
    int          respCount;
    int          cnt;
    logic        jumpEn;
    logic [31:0] jumpPc;
    logic [31:0] jumpTarget;
    logic [31:0] ovrAddr;
    logic [31:0] ovrData;

    logic [31:0] expAddr[$];
    dExp_t       expD[$];

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .d_jump_taken (d_jump_taken),
        .d_target     (d_target),
        .imBus        (imBus.master),
        .D_instr      (D_instr),
        .D_pc         (D_pc),
        .D_pc4        (D_pc4),
        .D_valid      (D_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'h2400, a[15:0]};
    endfunction

    // Memory model: fixed latency per request, limited to budgetTarget responses.
    assign imBus.im_rvalid = !reset && imBus.im_req && (respCount < budgetTarget) && (cnt >= lat);
    assign imBus.im_rdata  = (imBus.im_addr == ovrAddr) ? ovrData : memWord(imBus.im_addr);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 0;
            respCount <= 0;
        end else if (imBus.im_rvalid) begin
            cnt       <= 0;
            respCount <= respCount + 1;
        end else if (imBus.im_req) begin
            cnt <= cnt + 1;
        end
    end

    assign d_jump_taken = jumpEn && D_valid && (D_pc == jumpPc);
    assign d_target     = jumpTarget;

    // Monitor: each completed fetch and each instr leaving D is checked against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (imBus.im_req && imBus.im_rvalid) begin
                checks++;
                if (expAddr.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_addr: unexpected fetch at %h, required none", imBus.im_addr);
                end else begin
                    logic [31:0] ea;
                    ea = expAddr.pop_front();
                    if (imBus.im_addr !== ea) begin
                        errors++;
                        $display("FAIL fetch_addr: got %h, required %h", imBus.im_addr, ea);
                    end
                end
            end
            if (D_valid && !stall) begin
                checks++;
                if (expD.size() == 0) begin
                    errors++;
                    $display("FAIL d_out: unexpected D pc=%h instr=%h, required none", D_pc, D_instr);
                end else begin
                    dExp_t ed;
                    ed = expD.pop_front();
                    if (D_pc !== ed.pc || D_instr !== ed.instr || D_pc4 !== (ed.pc + 32'd4)) begin
                        errors++;
                        $display("FAIL d_out: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                 D_pc, D_instr, D_pc4, ed.pc, ed.instr, ed.pc + 32'd4);
                    end
                end
            end
            if (dut.redirPend && D_valid && d_jump_taken && !stall) begin
                errors++;
                $display("FAIL redir_overlap: got takeRedir with redirPend=1, required never");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushFetch(input logic [31:0] pc, input logic [31:0] instr);
        dExp_t e;
        e.pc    = pc;
        e.instr = instr;
        expAddr.push_back(pc);
        expD.push_back(e);
    endtask

    task automatic doReset(input int latV, input int n, input logic stallV);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        lat          = latV;
        budgetTarget = n;
        stall        = stallV;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && (expAddr.size() != 0 || expD.size() != 0); i++) begin
            @(negedge clk);
        end
        checks++;
        if (expAddr.size() != 0 || expD.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d addr / %0d D entries left, required 0",
                     name, expAddr.size(), expD.size());
        end
    endtask

    task automatic waitDPc(input string name, input logic [31:0] pc, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (D_valid && D_pc == pc) break;
        end
        checks++;
        if (i == limit) begin
            errors++;
            $display("FAIL %s_timeout: D_pc never reached %h, got %h", name, pc, D_pc);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        lat          = 0;
        budgetTarget = 0;
        jumpEn       = 1'b0;
        jumpPc       = 32'd0;
        jumpTarget   = 32'd0;
        ovrAddr      = 32'hFFFF_FFFF;
        ovrData      = 32'd0;

        // Reset values, then a request hanging with no response.
        repeat (2) @(negedge clk);
        chk("rst_D_valid", {31'd0, D_valid}, 32'd0);
        chk("rst_D_instr", D_instr, 32'h0000_0000);
        chk("rst_D_pc",    D_pc,    32'd0);
        chk("rst_D_pc4",   D_pc4,   32'd0);
        chk("rst_im_addr", imBus.im_addr, 32'h0000_3000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_im_req",  {31'd0, imBus.im_req}, 32'd1);
            chk("idle_im_addr", imBus.im_addr, 32'h0000_3000);
        end

        // Reset mid-request, then 1-cycle latency memory.
        pushFetch(32'h0000_3000, memWord(32'h0000_3000));
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        pushFetch(32'h0000_3008, memWord(32'h0000_3008));
        doReset(1, 3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imBus.im_rvalid) break;
        end
        chk("t1_first_rvalid", {31'd0, imBus.im_rvalid}, 32'd1);
        chk("t1_dvalid_before", {31'd0, D_valid}, 32'd0);
        @(negedge clk);
        chk("t1_dvalid_after", {31'd0, D_valid}, 32'd1);
        chk("t1_dpc_first", D_pc, 32'h0000_3000);
        waitDrain("t1");

        // Zero-latency memory: one instr per cycle, no bubbles.
        pushFetch(32'h0000_3000, memWord(32'h0000_3000));
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        pushFetch(32'h0000_3008, memWord(32'h0000_3008));
        pushFetch(32'h0000_300C, memWord(32'h0000_300C));
        doReset(0, 4, 1'b0);
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("t2_no_bubble", {31'd0, D_valid}, 32'd1);
        end
        waitDrain("t2");

        // Response arrives under a 3-cycle stall and is buffered.
        ovrAddr = 32'h0000_3000;
        ovrData = 32'h1234_5678;
        pushFetch(32'h0000_3000, 32'h1234_5678);
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        doReset(0, 2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_hold_req0", {31'd0, imBus.im_req}, 32'd0);
        chk("t3_hold_dvalid", {31'd0, D_valid}, 32'd0);
        @(negedge clk);
        chk("t3_hold_req0b", {31'd0, imBus.im_req}, 32'd0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_d_instr", D_instr, 32'h1234_5678);
        chk("t3_next_addr", imBus.im_addr, 32'h0000_3004);
        waitDrain("t3");
        ovrAddr = 32'hFFFF_FFFF;

        // Taken jal with delay slot arriving the same cycle; low target bits dropped.
        jumpEn     = 1'b1;
        jumpPc     = 32'h0000_3004;
        jumpTarget = 32'h0000_3101;
        pushFetch(32'h0000_3000, memWord(32'h0000_3000));
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        pushFetch(32'h0000_3008, memWord(32'h0000_3008));
        pushFetch(32'h0000_3100, memWord(32'h0000_3100));
        doReset(0, 4, 1'b0);
        waitDPc("t4", 32'h0000_3008, 20);
        chk("t4_target_addr", imBus.im_addr, 32'h0000_3100);
        waitDrain("t4");

        // Same jal, latency 3: delay slot late, redirect parked.
        jumpTarget = 32'h0000_3100;
        pushFetch(32'h0000_3000, memWord(32'h0000_3000));
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        pushFetch(32'h0000_3008, memWord(32'h0000_3008));
        pushFetch(32'h0000_3100, memWord(32'h0000_3100));
        doReset(3, 4, 1'b0);
        waitDPc("t5", 32'h0000_3004, 40);
        @(negedge clk);
        chk("t5_bubble_valid", {31'd0, D_valid}, 32'd0);
        chk("t5_bubble_instr", D_instr, 32'h0000_0000);
        chk("t5_redir_pend", {31'd0, dut.redirPend}, 32'd1);
        chk("t5_slot_addr", imBus.im_addr, 32'h0000_3008);
        waitDrain("t5");
        chk("t5_redir_clear", {31'd0, dut.redirPend}, 32'd0);

        // PC wrap at 2^32 via a jump to the last word.
        jumpTarget = 32'hFFFF_FFFC;
        pushFetch(32'h0000_3000, memWord(32'h0000_3000));
        pushFetch(32'h0000_3004, memWord(32'h0000_3004));
        pushFetch(32'h0000_3008, memWord(32'h0000_3008));
        pushFetch(32'hFFFF_FFFC, memWord(32'hFFFF_FFFC));
        pushFetch(32'h0000_0000, memWord(32'h0000_0000));
        doReset(0, 5, 1'b0);
        waitDPc("t6", 32'hFFFF_FFFC, 20);
        chk("t6_pc4_wrap", D_pc4, 32'h0000_0000);
        chk("t6_addr_wrap", imBus.im_addr, 32'h0000_0000);
        waitDrain("t6");
        jumpEn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage plus IF/ID pipeline register for the 5-stage MIPS core with branch delay slots.
- Owns F_PC and issues word fetches to an instruction memory over a request/valid interface with variable latency.
- Buffers one returned instruction while the pipeline is stalled.
- Presents instr/PC/PC+4 to the D stage. The D-stage next-PC logic computes the jump target and feeds it back as the redirect.

Parameters:
RESET_PC, 32'h0000_3000, F_PC value after reset
NOP_WORD, 32'h0000_0000, instr presented in D when D_valid=0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold F and D contents this cycle
d_jump_taken  in  1  instr in D is a taken beq/bne/jal/jr (qualified by D_valid)
d_target  in  32  jump/branch target from D-stage next-PC logic
im_req  out  1  fetch request, level; held until im_rvalid
im_addr  out  32  fetch address (= F_PC, word aligned)
im_rvalid  in  1  instruction word returned for the outstanding request
im_rdata  in  32  returned instruction word
D_instr  out  32  IF/ID instruction
D_pc  out  32  IF/ID PC
D_pc4  out  32  IF/ID PC+4
D_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async) values: F_PC=RESET_PC, state=REQ, buf_valid=0, redir_pend=0, redir_pc=0, D_valid=0, D_instr=NOP_WORD, D_pc=0, D_pc4=0. im_req=1 from the first cycle after reset is released. The instruction memory shares this reset, so no stale response survives a reset.
- States:
  - REQ: im_req=1, im_addr=F_PC.
  - HOLD: instr buffered in buf_instr; im_req=0.
- f_ready = (state==REQ && im_rvalid) || state==HOLD. f_instr = im_rvalid ? im_rdata : buf_instr.
- Advance (adv) = f_ready && !stall. On adv:
  - D_instr<=f_instr, D_pc<=F_PC, D_pc4<=F_PC+4, D_valid<=1.
  - F_PC<=next_f, state<=REQ.
- REQ && im_rvalid && stall: buf_instr<=im_rdata, state<=HOLD, F_PC unchanged.
- !stall && !f_ready: D_valid<=0, D_instr<=NOP_WORD (bubble inserted); F holds.
- stall=1: D_* hold; F_PC holds; an outstanding request stays outstanding (im_req stays 1 in REQ).
- Redirect, delay-slot semantics. A taken jump in D means the instr currently in F is its delay slot. take_redir = D_valid && d_jump_taken && !stall.
- next_f selection, in priority order:
  - redir_pend ? redir_pc
  - : take_redir ? d_target
  - : F_PC+4.
- take_redir && !f_ready (the delay slot has not arrived yet, the jump leaves D): redir_pend<=1, redir_pc<=d_target. Cleared on the next adv.
- take_redir && redir_pend cannot occur: D holds a bubble while a redirect is pending. The verifier asserts this.
- Arithmetic: 32-bit modulo; F_PC+4 wraps at 2^32 with no flag. Bits [1:0] of d_target are ignored (forced to 0).
- Only one request is ever outstanding. F_PC does not change while in REQ without im_rvalid.
- Zero-latency memory (im_rvalid in the same cycle as im_req) must sustain one instr per cycle with no bubbles.

Decomposition:
- Shared header cpu_defs.v (alongside the existing instruction-type defines): RESET_PC and NOP_WORD values; state encodings F_REQ=1'b0 and F_HOLD=1'b1.
- One natural sub-module: if_id_reg (D_instr/D_pc/D_pc4/D_valid with load/bubble/hold controls).
- F_PC, the FSM, the skid buffer and the redirect logic stay in fetch_stage.

Test Plan:
- Reset mid-request with im_rvalid held 0, then release; memory returns 1-cycle latency -> im_addr=0x3000, 0x3004, 0x3008 on consecutive fetches; D_valid rises one cycle after the first im_rvalid.
- Zero-latency memory, stall=0 for 4 cycles -> D_pc=0x3000, 0x3004, 0x3008, 0x300C back-to-back, never a bubble.
- im_rvalid with data 0x1234_5678 while stall=1 for 3 cycles -> state HOLD, im_req=0; after stall drops, D_instr=0x1234_5678 and the next im_addr=F_PC+4.
- D holds jal (d_jump_taken=1, d_target=0x3100), F delay slot at 0x3008 arrives that cycle -> D_pc=0x3008, next im_addr=0x3100.
- Same jal but memory latency 3, so F is not ready when the jal leaves D -> D_valid=0 bubble, redir_pend=1; delay slot 0x3008 enters D on arrival, then im_addr=0x3100; redir_pend clears.
- F_PC=0xFFFF_FFFC, fetch advances -> next im_addr=0x0000_0000.
